// File: rtl/bus_arbiter.sv
// Two-master serial bus arbiter with grant hold timeout and a one-cycle turnaround between owners.
// Optional feature macro: BUS_ARB_ROUND_ROBIN_EN (alternate winner on contention instead of fixed master-1 priority).
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic m1_req,
  input  logic m2_req,
  input  logic m1_done,
  input  logic m2_done,
  output logic m1_grant,
  output logic m2_grant,
  output logic msel,
  output logic bus_busy,
  output logic timeout
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_M1 = 2'd1,
    GRANT_M2 = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(TIMEOUT_CYCLES - 32'd1);
  localparam logic       MASTER_1   = 1'b0;
  localparam logic       MASTER_2   = 1'b1;

  state_t     state_r, state_s;
  logic [7:0] hold_cnt_r, hold_cnt_s;
  logic       last_grant_r, last_grant_s;
  logic       m1_grant_s, m2_grant_s, msel_s, bus_busy_s, timeout_s;
  logic       contend_m2_s;

  // Contention winner: the master that did not hold the bus last, or master 1 under fixed priority.
  always_comb begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
    contend_m2_s = (last_grant_r == MASTER_1);
`else
    contend_m2_s = 1'b0;
`endif
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s      = state_r;
    hold_cnt_s   = hold_cnt_r;
    last_grant_s = last_grant_r;
    m1_grant_s   = 1'b0;
    m2_grant_s   = 1'b0;
    msel_s       = msel;
    timeout_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if ((m1_req && !m2_req) || (m1_req && m2_req && !contend_m2_s)) begin
          state_s      = GRANT_M1;
          m1_grant_s   = 1'b1;
          msel_s       = MASTER_1;
          hold_cnt_s   = 8'd0;
          last_grant_s = MASTER_1;
        end else if (m2_req) begin
          state_s      = GRANT_M2;
          m2_grant_s   = 1'b1;
          msel_s       = MASTER_2;
          hold_cnt_s   = 8'd0;
          last_grant_s = MASTER_2;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT_M1: begin
        if (m1_done || !m1_req) begin
          state_s = RELEASE;
        end else if (hold_cnt_r == HOLD_LIMIT) begin
          state_s   = RELEASE;
          timeout_s = 1'b1;
        end else begin
          m1_grant_s = 1'b1;
          hold_cnt_s = (hold_cnt_r == 8'd255) ? 8'd255 : hold_cnt_r + 8'd1;
        end
      end
      GRANT_M2: begin
        if (m2_done || !m2_req) begin
          state_s = RELEASE;
        end else if (hold_cnt_r == HOLD_LIMIT) begin
          state_s   = RELEASE;
          timeout_s = 1'b1;
        end else begin
          m2_grant_s = 1'b1;
          hold_cnt_s = (hold_cnt_r == 8'd255) ? 8'd255 : hold_cnt_r + 8'd1;
        end
      end
      RELEASE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    bus_busy_s = (state_s != IDLE);
  end

  // State and registered outputs; reset wins over any grant in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      hold_cnt_r   <= 8'd0;
      last_grant_r <= MASTER_2;
      m1_grant     <= 1'b0;
      m2_grant     <= 1'b0;
      msel         <= 1'b0;
      bus_busy     <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state_r      <= state_s;
      hold_cnt_r   <= hold_cnt_s;
      last_grant_r <= last_grant_s;
      m1_grant     <= m1_grant_s;
      m2_grant     <= m2_grant_s;
      msel         <= msel_s;
      bus_busy     <= bus_busy_s;
      timeout      <= timeout_s;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios then random traffic against an ownership model.
// Honours BUS_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_bus_arbiter;
  localparam int T = 4;

  logic clk = 1'b0;
  logic reset, m1_req, m2_req, m1_done, m2_done;
  logic m1_grant, m2_grant, msel, bus_busy, timeout;
  int tests = 0;
  int fails = 0;

  // Model: who owns the bus, for how many cycles, and whether a turnaround cycle is in progress.
  int owner = 0;
  int held = 0;
  int last = 2;
  bit gap = 1'b0;
  logic e_msel = 1'b0;
  logic e_to = 1'b0;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .m1_req(m1_req), .m2_req(m2_req), .m1_done(m1_done), .m2_done(m2_done),
    .m1_grant(m1_grant), .m2_grant(m2_grant), .msel(msel),
    .bus_busy(bus_busy), .timeout(timeout)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int w;
    bit dn, rq;
    e_to = 1'b0;
    if (reset) begin
      owner = 0; held = 0; gap = 1'b0; last = 2; e_msel = 1'b0;
    end else if (gap) begin
      gap = 1'b0;
    end else if (owner != 0) begin
      dn = (owner == 1) ? m1_done : m2_done;
      rq = (owner == 1) ? m1_req : m2_req;
      if (dn || !rq) begin
        owner = 0; gap = 1'b1;
      end else if (held == T) begin
        owner = 0; gap = 1'b1; e_to = 1'b1;
      end else begin
        held++;
      end
    end else begin
      w = 0;
      if (m1_req && m2_req) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
        w = (last == 1) ? 2 : 1;
`else
        w = 1;
`endif
      end else if (m1_req) w = 1;
      else if (m2_req) w = 2;
      if (w != 0) begin
        owner = w; held = 1; last = w; e_msel = (w == 2);
      end
    end
  endtask

  // One clock: advance the model on the inputs seen at this edge, then compare just after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("m1_grant", m1_grant, owner == 1);
    check("m2_grant", m2_grant, owner == 2);
    check("msel", msel, e_msel);
    check("bus_busy", bus_busy, (owner != 0) || gap);
    check("timeout", timeout, e_to);
    check("grant_excl", m1_grant & m2_grant, 1'b0);
  endtask

  task automatic settle();
    m1_req = 1'b0; m2_req = 1'b0; m1_done = 1'b0; m2_done = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    int hi;
    reset = 1'b1; m1_req = 1'b0; m2_req = 1'b0; m1_done = 1'b0; m2_done = 1'b0;
    tick(); tick();
    check("rst_grant", m1_grant | m2_grant, 1'b0);
    check("rst_busy", bus_busy, 1'b0);
    check("rst_msel", msel, 1'b0);
    reset = 1'b0;
    tick();

    // Contention straight after reset: master 1 wins in both modes.
    m1_req = 1'b1; m2_req = 1'b1;
    tick();
    check("cont_first_m1", m1_grant, 1'b1);
    tick();
    m1_done = 1'b1; tick(); m1_done = 1'b0;
    check("cont_release", m1_grant, 1'b0);
    check("cont_release_busy", bus_busy, 1'b1);
    tick();
    check("cont_idle_busy", bus_busy, 1'b0);
    tick();
`ifdef BUS_ARB_ROUND_ROBIN_EN
    check("cont_rr_m2", m2_grant, 1'b1);
    check("cont_rr_msel", msel, 1'b1);
`else
    check("cont_fixed_m1", m1_grant, 1'b1);
    check("cont_fixed_msel", msel, 1'b0);
`endif
    settle();

    // Single requester with done.
    m1_req = 1'b1; tick();
    check("single_grant", m1_grant, 1'b1);
    check("single_busy", bus_busy, 1'b1);
    tick(); tick();
    m1_done = 1'b1; tick(); m1_done = 1'b0; m1_req = 1'b0;
    check("single_drop", m1_grant, 1'b0);
    tick();
    check("single_idle", bus_busy, 1'b0);
    settle();

    // Timeout: grant held exactly T cycles, pulse on first low cycle.
    m2_req = 1'b1; tick();
    hi = 0;
    while (m2_grant === 1'b1 && hi < 20) begin
      hi++;
      tick();
    end
    check_int("to_len", hi, T);
    check("to_pulse", timeout, 1'b1);
    tick();
    check("to_pulse_end", timeout, 1'b0);
    settle();

    // Withdrawal with a stray done from the other master.
    m1_req = 1'b1; tick();
    m2_done = 1'b1; tick(); m2_done = 1'b0;
    check("stray_done", m1_grant, 1'b1);
    m1_req = 1'b0; tick();
    check("withdraw_drop", m1_grant, 1'b0);
    check("withdraw_noto", timeout, 1'b0);
    settle();

    // Done coinciding with expiry: no timeout pulse.
    m1_req = 1'b1; tick();
    repeat (T - 1) tick();
    m1_done = 1'b1; tick(); m1_done = 1'b0;
    check("done_exp_drop", m1_grant, 1'b0);
    check("done_exp_noto", timeout, 1'b0);
    settle();

    // Reset mid-grant, then contention favours master 1.
    m2_req = 1'b1; tick(); tick();
    reset = 1'b1; tick();
    check("rst_mid_g2", m2_grant, 1'b0);
    check("rst_mid_busy", bus_busy, 1'b0);
    reset = 1'b0; m1_req = 1'b1; m2_req = 1'b1; tick();
    check("rst_cont_m1", m1_grant, 1'b1);
    settle();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) m1_req = ~m1_req;
      if ($urandom_range(0, 3) == 0) m2_req = ~m2_req;
      m1_done = ($urandom_range(0, 7) == 0);
      m2_done = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
